// File: rtl/store_arb_pkg.sv
// store_arb_pkg: shared sizes, FSM state type and one-hot helper for store_arbiter
package store_arb_pkg;
  localparam int N_REQ = 16;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int REQ_IDX_W = 4;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} arb_state_t;
  function automatic logic [N_REQ-1:0] onehot(input logic [REQ_IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner search starting at rr_ptr
module rr_picker
  import store_arb_pkg::*;
(
  input  logic [N_REQ-1:0]     req,
  input  logic [REQ_IDX_W-1:0] rr_ptr,
  output logic [REQ_IDX_W-1:0] winner_idx,
  output logic                 winner_valid
);
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0] rot;
  logic [REQ_IDX_W-1:0] off;
  assign dbl = {req, req} >> rr_ptr;
  assign rot = dbl[N_REQ-1:0];
  // lowest set bit of the rotated vector is the offset from rr_ptr
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) off = REQ_IDX_W'(i);
  end
  assign winner_idx = rr_ptr + off;
  assign winner_valid = |req;
endmodule

// File: rtl/store_arbiter.sv
// store_arbiter: round-robin serialiser of core stores onto one memory write port (option: STORE_ARB_PERF_EN adds store_count)
module store_arbiter
  import store_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    mem_wr_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ready,
  output logic                    busy
`ifdef STORE_ARB_PERF_EN
  ,
  output logic [15:0]             store_count
`endif
);
  arb_state_t state, next_state;
  logic [REQ_IDX_W-1:0] rr_ptr, winner_idx;
  logic winner_valid;
  rr_picker u_pick (
    .req(req),
    .rr_ptr(rr_ptr),
    .winner_idx(winner_idx),
    .winner_valid(winner_valid)
  );
  // next state: IDLE waits for any request, WRITE waits for memory, DONE lasts one cycle
  always_comb begin
    next_state = state == IDLE  ? (winner_valid ? WRITE : IDLE) :
                 state == WRITE ? (mem_ready ? DONE : WRITE) : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end
  // registered outputs: latch winner on grant, pulse ack on acceptance, release in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      ack <= '0;
      mem_wr_en <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rr_ptr <= '0;
      busy <= 1'b0;
    end else begin
      ack <= '0;
      busy <= next_state != IDLE;
      if (state == IDLE && winner_valid) begin
        grant <= onehot(winner_idx);
        mem_addr <= req_addr[winner_idx*ADDR_W +: ADDR_W];
        mem_wdata <= req_data[winner_idx*DATA_W +: DATA_W];
        rr_ptr <= winner_idx + 1'b1;
        mem_wr_en <= 1'b1;
      end
      if (state == WRITE && mem_ready) begin
        mem_wr_en <= 1'b0;
        ack <= grant;
      end
      if (state == DONE) grant <= '0;
    end
  end
`ifdef STORE_ARB_PERF_EN
  // completed-store counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) store_count <= '0;
    else if (state == DONE) store_count <= store_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_store_arbiter.sv
// tb_store_arbiter: randomized self-checking bench for store_arbiter against a transaction-level model
module tb_store_arbiter;
  logic clk = 0;
  logic rst = 1;
  logic [15:0] req = 0;
  logic [255:0] req_addr = 0, req_data = 0;
  logic mem_ready = 0;
  logic [15:0] ack, grant, mem_addr, mem_wdata;
  logic mem_wr_en, busy;
`ifdef STORE_ARB_PERF_EN
  logic [15:0] store_count;
`endif
  int errors = 0, checks = 0, ptr = 0;

  store_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .grant(grant), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy)
`ifdef STORE_ARB_PERF_EN
    , .store_count(store_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) if (r[(p + k) % 16]) return (p + k) % 16;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req = 0; mem_ready = 0;
    tick();
    rst = 0; ptr = 0;
  endtask

  task automatic scramble();
    for (int i = 0; i < 16; i++) begin
      req_addr[i*16 +: 16] = 16'($urandom);
      req_data[i*16 +: 16] = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1; req = '1; mem_ready = 1; scramble();
    tick(); tick();
    checks++;
    if ({grant, ack} !== 32'h0) begin errors++; $display("FAIL reset_grant_ack: got %h %h want 0 0", grant, ack); end
    checks++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin errors++; $display("FAIL reset_addr_data: got %h %h want 0 0", mem_addr, mem_wdata); end
    checks++;
    if ({mem_wr_en, busy} !== 2'b00) begin errors++; $display("FAIL reset_wr_busy: got %b%b want 00", mem_wr_en, busy); end
    rst = 0; req = 0; ptr = 0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req: busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    req_addr[3*16 +: 16] = 16'h1234; req_data[3*16 +: 16] = 16'hBEEF;
    req = 16'h0008; mem_ready = 1;
    tick();
    checks++;
    if ({grant, mem_wr_en, busy, ack} !== {16'h0008, 2'b11, 16'h0}) begin errors++; $display("FAIL single_c1: grant %h wr %b busy %b ack %h want 0008 1 1 0000", grant, mem_wr_en, busy, ack); end
    checks++;
    if ({mem_addr, mem_wdata} !== {16'h1234, 16'hBEEF}) begin errors++; $display("FAIL single_data: got %h %h want 1234 beef", mem_addr, mem_wdata); end
    req = 0;
    tick();
    checks++;
    if ({ack, mem_wr_en} !== {16'h0008, 1'b0}) begin errors++; $display("FAIL single_ack: ack %h wr %b want 0008 0", ack, mem_wr_en); end
    tick();
    checks++;
    if ({busy, grant, ack} !== 33'h0) begin errors++; $display("FAIL single_c3: busy %b grant %h ack %h want 0 0 0", busy, grant, ack); end
    ptr = 4;
  endtask

  task automatic test_fairness();
    int cnt[16];
    int bad, w;
    do_reset();
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    req = '1; mem_ready = 1;
    for (int s = 0; s < 16; s++) begin
      w = pick(req, ptr);
      tick();
      checks++;
      if (grant !== 16'(1) << w) begin errors++; $display("FAIL fair_grant%0d: got %h want %h", s, grant, 16'(1) << w); end
      tick();
      for (int i = 0; i < 16; i++) if (ack[i]) cnt[i]++;
      tick();
      ptr = (w + 1) % 16;
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (cnt[i] != 1) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fair_acks: %0d cores not acked exactly once, want 0", bad); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_g[2];
    exp_g[0] = 16'h0001; exp_g[1] = 16'h8000;
    req = 16'h8001; mem_ready = 1;
    for (int s = 0; s < 2; s++) begin
      tick();
      checks++;
      if (grant !== exp_g[s]) begin errors++; $display("FAIL wrap_grant%0d: got %h want %h", s, grant, exp_g[s]); end
      tick(); tick();
    end
    req = 0; ptr = 0;
  endtask

  task automatic test_backpressure();
    logic [15:0] a, d;
    do_reset();
    scramble();
    a = req_addr[2*16 +: 16]; d = req_data[2*16 +: 16];
    req = 16'h0004; mem_ready = 0;
    tick();
    checks++;
    if ({grant, mem_wr_en} !== {16'h0004, 1'b1}) begin errors++; $display("FAIL bp_grant: grant %h wr %b want 0004 1", grant, mem_wr_en); end
    req = 0; scramble();
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({mem_wr_en, mem_addr, mem_wdata, ack} !== {1'b1, a, d, 16'h0}) begin errors++; $display("FAIL bp_hold%0d: wr %b addr %h data %h ack %h want 1 %h %h 0000", c, mem_wr_en, mem_addr, mem_wdata, ack, a, d); end
    end
    mem_ready = 1;
    tick();
    checks++;
    if ({ack, mem_wr_en} !== {16'h0004, 1'b0}) begin errors++; $display("FAIL bp_ack: ack %h wr %b want 0004 0", ack, mem_wr_en); end
    mem_ready = 0;
    tick();
    checks++;
    if ({ack, busy, grant} !== 33'h0) begin errors++; $display("FAIL bp_end: ack %h busy %b grant %h want 0 0 0", ack, busy, grant); end
    ptr = 3;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    scramble();
    req_addr[4*16 +: 16] = 16'hA5A5;
    req = 16'h0010; mem_ready = 0;
    tick();
    checks++;
    if ({grant, mem_addr} !== {16'h0010, 16'hA5A5}) begin errors++; $display("FAIL rmw_grant: grant %h addr %h want 0010 a5a5", grant, mem_addr); end
    rst = 1; req = 0; mem_ready = 1;
    tick();
    checks++;
    if ({grant, ack, mem_wr_en, busy, mem_addr, mem_wdata} !== 66'h0) begin errors++; $display("FAIL rmw_clear: grant %h ack %h wr %b busy %b addr %h data %h want all 0", grant, ack, mem_wr_en, busy, mem_addr, mem_wdata); end
    rst = 0; req = 16'h0030;
    tick();
    checks++;
    if (grant !== 16'h0010) begin errors++; $display("FAIL rmw_regrant: got %h want 0010", grant); end
    req = 0;
    tick(); tick();
    ptr = 5;
  endtask

  task automatic test_random();
    int w, k;
    logic [15:0] a, d;
    for (int s = 0; s < 40; s++) begin
      scramble();
      req = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
      mem_ready = 1'($urandom);
      w = pick(req, ptr);
      if (w < 0) begin
        tick();
        checks++;
        if ({busy, grant} !== 17'h0) begin errors++; $display("FAIL rnd_idle%0d: busy %b grant %h want 0 0", s, busy, grant); end
        continue;
      end
      a = req_addr[w*16 +: 16]; d = req_data[w*16 +: 16];
      tick();
      checks++;
      if ({grant, mem_wr_en, mem_addr, mem_wdata} !== {16'(1) << w, 1'b1, a, d}) begin errors++; $display("FAIL rnd_grant%0d: grant %h wr %b addr %h data %h want %h 1 %h %h", s, grant, mem_wr_en, mem_addr, mem_wdata, 16'(1) << w, a, d); end
      k = $urandom_range(0, 3);
      for (int c = 0; c < k; c++) begin
        mem_ready = 0; req = 16'($urandom); scramble();
        tick();
        checks++;
        if ({mem_wr_en, mem_addr, mem_wdata, ack} !== {1'b1, a, d, 16'h0}) begin errors++; $display("FAIL rnd_stall%0d: wr %b addr %h data %h ack %h", s, mem_wr_en, mem_addr, mem_wdata, ack); end
      end
      mem_ready = 1;
      tick();
      checks++;
      if (ack !== 16'(1) << w) begin errors++; $display("FAIL rnd_ack%0d: got %h want %h", s, ack, 16'(1) << w); end
      req = 16'($urandom); mem_ready = 1'($urandom);
      tick();
      checks++;
      if ({busy, ack} !== 17'h0) begin errors++; $display("FAIL rnd_done%0d: busy %b ack %h want 0 0", s, busy, ack); end
      ptr = (w + 1) % 16;
    end
    req = 0;
  endtask

`ifdef STORE_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    checks++;
    if (store_count !== 16'd0) begin errors++; $display("FAIL perf_reset: got %0d want 0", store_count); end
    req = 16'h0001; mem_ready = 1;
    repeat (3) begin tick(); tick(); tick(); end
    req = 0;
    tick();
    checks++;
    if (store_count !== 16'd3) begin errors++; $display("FAIL perf_count: got %0d want 3", store_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_backpressure();
    test_reset_mid_write();
    test_random();
`ifdef STORE_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
